sm_reg_dump: RTL and testbench
==============================

// Module: sm_reg_dump
//
// PURPOSE
//  Reader side of the register debug port (regAddr/regData) of sm_arm. On a start pulse, it
//  sweeps register addresses 0..NUM_REGS-1 and samples regData for each address.
//  It streams a sync byte followed by every register value out of a UART 8N1 serial line.
//  Sits beside sm_arm in sm_top and replaces a manual regAddr switch for board-level debug.
//
// PARAMETERS
//  CLK_PER_BIT  16   clk cycles per UART bit; legal range >= 2
//  NUM_REGS     16   registers dumped per frame, addresses 0..NUM_REGS-1; legal range 1..16
//  SYNC_BYTE    8'hA5 first byte of every frame
//
// PORTS
//  clk      in   1   single clock; all logic on the rising edge
//  rst_p    in   1   synchronous, active-high reset
//  start    in   1   request a dump; sampled only in IDLE
//  busy     out  1   high from the cycle after start is accepted until done
//  done     out  1   one-cycle pulse when the frame is complete
//  regAddr  out  4   register address driven to sm_arm
//  regData  in   32  combinational register read data from sm_arm
//  tx       out  1   UART serial output; idle high
//
// BEHAVIOUR
//  - Reset values: tx=1, busy=0, done=0, regAddr=0, FSM in IDLE, all counters 0.
//  - All outputs are registered.
//  - Reset mid-frame aborts the frame. tx=1 is visible after the reset edge, and no done pulse occurs.
//  - UART byte format:
//      - start bit 0, then 8 data bits LSB first, then stop bit 1.
//      - Each bit lasts exactly CLK_PER_BIT cycles, so one byte takes 10*CLK_PER_BIT cycles.
//  - Frame layout: SYNC_BYTE, then for each register i = 0..NUM_REGS-1 four bytes.
//      - Byte order is regData[7:0], [15:8], [23:16], [31:24] (little-endian).
//  - FSM states: IDLE, SYNC, ADDR, CAPT, SEND, DONE.
//  - FSM transitions:
//      - IDLE: start=1 -> SYNC. busy=1 and tx=0 (SYNC start bit) on the next cycle.
//      - SYNC: sends SYNC_BYTE -> ADDR.
//      - ADDR: one cycle; regAddr <= reg_idx -> CAPT.
//      - CAPT: one cycle; shift_reg <= regData (regAddr now stable) -> SEND.
//      - SEND: 4 bytes back-to-back, no gap. After the last stop bit:
//          - reg_idx < NUM_REGS-1: reg_idx++ -> ADDR.
//          - otherwise -> DONE.
//      - DONE: one cycle with done=1 and busy=0 on the following cycle -> IDLE.
//  - tx=1 during ADDR and CAPT, giving an exact 2-cycle idle gap before each register's data.
//  - Frame length, measured from the start-sample edge to the done pulse:
//      - (1+4*NUM_REGS)*10*CLK_PER_BIT + 2*NUM_REGS + 1 cycles.
//  - start while busy or in DONE is ignored; it is not queued.
//  - start held high re-triggers only on IDLE entry, so a new frame begins the cycle after DONE.
//  - regData is sampled only in CAPT. Changes during SEND do not affect the transmitted bytes.
//  - regAddr holds its last value after the frame; it returns to 0 only on reset.
//  - Counter widths:
//      - bit_cnt: $clog2(CLK_PER_BIT) bits, wraps to 0 at CLK_PER_BIT-1.
//      - bit index: 0..9.
//      - byte index: 0..3.
//      - reg_idx: 4 bits.
//
// STRUCTURE
//  - Package sm_dbg_pkg holds:
//      - state enum typedef dump_state_t.
//      - UART_START=1'b0 and UART_STOP=1'b1.
//      - DEFAULT_SYNC_BYTE = 8'hA5.
//  - Sub-module sm_uart_tx (byte transmitter with CLK_PER_BIT parameter):
//      - Inputs: clk, rst_p, data[7:0], valid.
//      - Outputs: ready, tx.
//      - Accepts a byte when valid && ready. Asserts ready in the final cycle of the stop bit,
//        so the next byte's start bit follows immediately.
//  - sm_reg_dump owns the frame FSM, reg_idx, byte index and 32-bit capture register.
//
// TESTING
//  - Use CLK_PER_BIT=4, NUM_REGS=2, and a register file model with R0=32'h1234_5678, R1=32'hDEAD_BEEF.
//  - Full frame: pulse start -> UART model decodes A5 78 56 34 12 EF BE AD DE.
//      - done pulses exactly 9*40+4+1 = 365 cycles after the start edge.
//  - Timing: verify each bit is exactly 4 cycles and the tx=1 gap before each register is exactly 2 cycles.
//      - Verify regAddr=0 during reg 0 bytes and regAddr=1 during reg 1 bytes.
//  - Start ignored: pulse start again at cycle 50 and cycle 200 -> one frame only; busy stays 1 and one done.
//  - Data isolation: change R0 to 32'h0 during SEND of reg 0 -> bytes still 78 56 34 12.
//  - Reset mid-frame: assert rst_p at cycle 120 for 1 cycle.
//      - Next cycle: tx=1, busy=0, regAddr=0, no done.
//      - A new start then yields a complete, correct frame.
//  - start held high continuously -> back-to-back frames; the new start bit appears 1 cycle after each done pulse.

Source files
------------

// File: rtl/sm_dbg_pkg.sv
// Shared types and constants for the debug register dump path.
package sm_dbg_pkg;

   typedef enum logic [2:0] {IDLE, SYNC, ADDR, CAPT, SEND, DONE} dump_state_t;

   localparam logic UART_START = 1'b0;
   localparam logic UART_STOP = 1'b1;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/sm_uart_tx.sv
// UART 8N1 byte transmitter. ready rises in the last cycle of the stop bit so
// a byte offered then starts with no gap.
module sm_uart_tx
   import sm_dbg_pkg::*;
#(
   parameter int CLK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_p,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

   logic             active;
   logic [CNT_W-1:0] bitCnt;
   logic [3:0]       bitIdx;
   logic [7:0]       shiftReg;

   assign ready = !active || (bitIdx == 4'd9 && bitCnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst_p) begin
         active   <= 1'b0;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         tx       <= UART_STOP;
      end else if (valid && ready) begin
         active   <= 1'b1;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= data;
         tx       <= UART_START;
      end else if (active) begin
         if (bitCnt == CNT_LAST) begin
            bitCnt <= '0;
            if (bitIdx == 4'd9) begin
               active <= 1'b0;
               bitIdx <= '0;
               tx     <= UART_STOP;
            end else begin
               bitIdx <= bitIdx + 4'd1;
               // bitIdx 8 -> 9 enters the stop bit; earlier steps shift out data LSB first
               if (bitIdx == 4'd8) begin
                  tx <= UART_STOP;
               end else begin
                  tx       <= shiftReg[0];
                  shiftReg <= {1'b0, shiftReg[7:1]};
               end
            end
         end else begin
            bitCnt <= bitCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sm_reg_dump.sv
// Sweeps the sm_arm register debug port and streams a sync byte plus every
// register (little-endian) out of a UART line.
//
// state | meaning
// IDLE  | waiting for start; sync byte is handed to the UART as start is taken
// SYNC  | sync byte on the line
// ADDR  | drive regAddr for the next register (tx idle)
// CAPT  | regData valid; capture it and launch its low byte (tx idle)
// SEND  | remaining three bytes of the register, back to back
// DONE  | frame finished; pulse done, drop busy
module sm_reg_dump
   import sm_dbg_pkg::*;
#(
   parameter int         CLK_PER_BIT = 16,
   parameter int         NUM_REGS    = 16,
   parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
   input  logic        clk,
   input  logic        rst_p,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [3:0]  regAddr,
   input  logic [31:0] regData,
   output logic        tx
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   dump_state_t state;
   logic [3:0]  regIdx;
   logic [1:0]  byteIdx;
   logic [31:0] capReg;
   logic        txValid;
   logic        txReady;
   logic [7:0]  txData;

   // capReg rotates right one byte per accepted byte, so [15:8] is always the next one
   always_comb begin
      txValid = 1'b0;
      txData  = capReg[15:8];
      unique case (state)
         IDLE: begin
            txValid = start;
            txData  = SYNC_BYTE;
         end
         CAPT: begin
            txValid = 1'b1;
            txData  = regData[7:0];
         end
         SEND: txValid = txReady && (byteIdx != 2'd3);
         default: txValid = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         state   <= IDLE;
         regIdx  <= '0;
         byteIdx <= '0;
         capReg  <= '0;
         regAddr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= SYNC;
                  busy   <= 1'b1;
                  regIdx <= '0;
               end
            end
            SYNC: if (txReady) state <= ADDR;
            ADDR: begin
               regAddr <= regIdx;
               state   <= CAPT;
            end
            CAPT: begin
               capReg  <= regData;
               byteIdx <= '0;
               state   <= SEND;
            end
            SEND: begin
               if (txReady) begin
                  if (byteIdx != 2'd3) begin
                     byteIdx <= byteIdx + 2'd1;
                     capReg  <= {capReg[7:0], capReg[31:8]};
                  end else if (regIdx < LAST_IDX) begin
                     regIdx <= regIdx + 4'd1;
                     state  <= ADDR;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sm_uart_tx #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) uTx (
      .clk  (clk),
      .rst_p(rst_p),
      .data (txData),
      .valid(txValid),
      .ready(txReady),
      .tx   (tx)
   );

endmodule

// File: tb/tb_sm_reg_dump.sv
// Bench for sm_reg_dump: records tx/regAddr/busy per cycle and compares
// against a byte-list / waveform model built from the frame rules.
module tb_sm_reg_dump;

   localparam int C = 4;
   localparam int N = 2;
   localparam int FRAME_LEN = (1 + 4 * N) * 10 * C + 2 * N + 1;
   localparam int TMAX = 1024;

   logic        clk = 1'b0;
   logic        rst_p = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, tx;
   logic [3:0]  regAddr;
   logic [31:0] regData;
   logic [31:0] r0, r1;

   int checks = 0;
   int failures = 0;

   logic       trTx[TMAX];
   logic [3:0] trAddr[TMAX];
   logic       trBusy[TMAX];

   always #5 clk = ~clk;

   always_comb begin
      regData = 32'h0;
      if (regAddr == 4'd0) regData = r0;
      else if (regAddr == 4'd1) regData = r1;
   end

   sm_reg_dump #(.CLK_PER_BIT(C), .NUM_REGS(N), .SYNC_BYTE(8'hA5)) dut (
      .clk    (clk),
      .rst_p  (rst_p),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .regAddr(regAddr),
      .regData(regData),
      .tx     (tx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Records one frame; cycle 0 is the cycle right after the start-sample edge.
   task automatic capture(input bit doStart, input bit holdStart, input bit extraStarts,
                          input bit zeroR0, output int doneAt);
      doneAt = -1;
      if (doStart) begin
         start = 1'b1;
         tick();
         start = holdStart;
      end
      for (int t = 0; t < TMAX; t++) begin
         trTx[t]   = tx;
         trAddr[t] = regAddr;
         trBusy[t] = busy;
         if (done === 1'b1) begin
            doneAt = t;
            break;
         end
         if (zeroR0 && t == 60) r0 = 32'h0;
         start = holdStart || (extraStarts && (t == 49 || t == 199));
         tick();
      end
   endtask

   task automatic check_frame(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input int doneAt);
      logic [7:0] bytes[$];
      logic       wave[$];
      logic [7:0] dec[$];
      logic [31:0] regs[2];
      int last, busyCnt, firstBad, scanFrom, bad;
      logic expBit;
      logic [7:0] b;
      last = (doneAt < 0) ? TMAX - 1 : doneAt;
      chk({name, ".done_latency"}, doneAt, FRAME_LEN);

      busyCnt = 0;
      for (int t = 0; t < last; t++) if (trBusy[t] === 1'b1) busyCnt++;
      chk({name, ".busy_high"}, busyCnt, last);
      chk({name, ".busy_at_done"}, trBusy[last], 1'b0);

      regs[0] = e0;
      regs[1] = e1;
      bytes.push_back(8'hA5);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 4; k++) bytes.push_back(regs[i][8*k +: 8]);

      // Expected line: 2 idle cycles before each register, 10 bits of C cycles per byte
      for (int j = 0; j < bytes.size(); j++) begin
         if (j >= 1 && (j - 1) % 4 == 0) begin
            wave.push_back(1'b1);
            wave.push_back(1'b1);
         end
         for (int bit_i = 0; bit_i < 10; bit_i++) begin
            b = bytes[j];
            expBit = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : b[bit_i - 1];
            for (int c = 0; c < C; c++) wave.push_back(expBit);
         end
      end
      firstBad = -1;
      for (int t = 0; t <= last; t++) begin
         expBit = (t < wave.size()) ? wave[t] : 1'b1;
         if (trTx[t] !== expBit && firstBad < 0) firstBad = t;
      end
      chk({name, ".tx_wave_first_bad"}, firstBad, -1);

      // Independent mid-bit UART decode of the recorded line
      scanFrom = 0;
      for (int t = 0; t <= last; t++) begin
         if (t >= scanFrom && trTx[t] === 1'b0) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) begin
               if (t + C * (k + 1) + C / 2 < TMAX) b[k] = trTx[t + C * (k + 1) + C / 2];
               else b[k] = 1'bx;
            end
            if (t + 9 * C + C / 2 >= TMAX || trTx[t + 9 * C + C / 2] !== 1'b1) b = 8'hxx;
            dec.push_back(b);
            scanFrom = t + 10 * C;
         end
      end
      chk({name, ".byte_count"}, dec.size(), bytes.size());
      for (int j = 0; j < bytes.size(); j++)
         chk($sformatf("%s.byte%0d", name, j), (j < dec.size()) ? dec[j] : 8'hxx, bytes[j]);

      for (int i = 0; i < N; i++) begin
         bad = 0;
         for (int t = 10 * C + i * (2 + 40 * C) + 2; t < 10 * C + (i + 1) * (2 + 40 * C); t++)
            if (trAddr[t] !== 4'(i)) bad++;
         chk($sformatf("%s.regaddr_r%0d_bad_cycles", name, i), bad, 0);
      end
   endtask

   task automatic after_frame(input string name);
      tick();
      chk({name, ".done_width"}, done, 1'b0);
      chk({name, ".busy_after"}, busy, 1'b0);
      chk({name, ".regaddr_hold"}, regAddr, 4'(N - 1));
   endtask

   initial begin
      int doneAt, bad;
      logic [31:0] a0, a1;
      r0 = 32'h1234_5678;
      r1 = 32'hDEAD_BEEF;

      rst_p = 1'b1;
      repeat (3) tick();
      chk("reset.tx", tx, 1'b1);
      chk("reset.busy", busy, 1'b0);
      chk("reset.done", done, 1'b0);
      chk("reset.regaddr", regAddr, 4'd0);
      rst_p = 1'b0;
      tick();

      // Directed frame
      capture(1, 0, 0, 0, doneAt);
      check_frame("directed", 32'h1234_5678, 32'hDEAD_BEEF, doneAt);
      after_frame("directed");

      // Random data with ignored start pulses, then a quiet line
      a0 = $urandom();
      a1 = $urandom();
      r0 = a0;
      r1 = a1;
      repeat (3) tick();
      capture(1, 0, 1, 0, doneAt);
      check_frame("ignored_start", a0, a1, doneAt);
      after_frame("ignored_start");
      bad = 0;
      for (int t = 0; t < 40; t++) begin
         if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      chk("ignored_start.quiet_after", bad, 0);

      // R0 changes during its SEND phase; transmitted bytes must not
      r0 = 32'h1234_5678;
      r1 = 32'hDEAD_BEEF;
      capture(1, 0, 0, 1, doneAt);
      check_frame("isolation", 32'h1234_5678, 32'hDEAD_BEEF, doneAt);
      after_frame("isolation");

      // Reset at cycle 120 of a frame
      r0 = $urandom();
      r1 = $urandom();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (119) tick();
      rst_p = 1'b1;
      tick();
      rst_p = 1'b0;
      chk("midreset.tx", tx, 1'b1);
      chk("midreset.busy", busy, 1'b0);
      chk("midreset.regaddr", regAddr, 4'd0);
      chk("midreset.done", done, 1'b0);
      bad = 0;
      for (int t = 0; t < 400; t++) begin
         if (done !== 1'b0 || tx !== 1'b1) bad++;
         tick();
      end
      chk("midreset.no_activity", bad, 0);

      a0 = $urandom();
      a1 = $urandom();
      r0 = a0;
      r1 = a1;
      capture(1, 0, 0, 0, doneAt);
      check_frame("post_reset", a0, a1, doneAt);
      after_frame("post_reset");

      // start held high: back-to-back frames
      a0 = $urandom();
      a1 = $urandom();
      r0 = a0;
      r1 = a1;
      capture(1, 1, 0, 0, doneAt);
      check_frame("held1", a0, a1, doneAt);
      tick();
      start = 1'b0;
      chk("held.restart_tx", tx, 1'b0);
      chk("held.restart_busy", busy, 1'b1);
      capture(0, 0, 0, 0, doneAt);
      check_frame("held2", a0, a1, doneAt);
      after_frame("held2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
